// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection; 1-cycle latency.
// Stalls by inserting a bubble; i_enable=0 freezes all state, and flush overrides stall.
module id_ex_stage_reg #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_CTRL = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_enable,
  input  logic               i_flush,
  input  logic               i_id_valid,
  input  logic [NB_CTRL-1:0] i_ctrl,
  input  logic [NB_DATA-1:0] i_pc4,
  input  logic [NB_DATA-1:0] i_rs_data,
  input  logic [NB_DATA-1:0] i_rt_data,
  input  logic [NB_DATA-1:0] i_imm,
  input  logic [NB_REG-1:0]  i_rs_addr,
  input  logic [NB_REG-1:0]  i_rt_addr,
  input  logic [NB_REG-1:0]  i_rd_addr,
  input  logic [4:0]         i_shamt,
  input  logic [5:0]         i_funct,
  output logic [NB_CTRL-1:0] o_ctrl,
  output logic [NB_DATA-1:0] o_pc4,
  output logic [NB_DATA-1:0] o_rs_data,
  output logic [NB_DATA-1:0] o_rt_data,
  output logic [NB_DATA-1:0] o_imm,
  output logic [NB_REG-1:0]  o_rs_addr,
  output logic [NB_REG-1:0]  o_rt_addr,
  output logic [NB_REG-1:0]  o_rd_addr,
  output logic [4:0]         o_shamt,
  output logic [5:0]         o_funct,
  output logic               o_ex_valid,
  output logic               o_stall
);

  // Mem_read sits just above Reg_dst[1:0] and Size_control[4:0].
  localparam int MEM_READ_BIT = 7;

  typedef struct packed {
    logic [NB_DATA-1:0] pc4;
    logic [NB_DATA-1:0] rs_data;
    logic [NB_DATA-1:0] rt_data;
    logic [NB_DATA-1:0] imm;
    logic [NB_REG-1:0]  rs_addr;
    logic [NB_REG-1:0]  rt_addr;
    logic [NB_REG-1:0]  rd_addr;
    logic [4:0]         shamt;
    logic [5:0]         funct;
  } payload_t;

  payload_t           payload_d;
  payload_t           payload_q;
  logic [NB_CTRL-1:0] ctrl_q;
  logic               ex_valid_q;
  logic               ex_mem_read;
  logic               rt_match;
  logic               stall;
  logic               bubble;

  assign payload_d = '{
    pc4:     i_pc4,
    rs_data: i_rs_data,
    rt_data: i_rt_data,
    imm:     i_imm,
    rs_addr: i_rs_addr,
    rt_addr: i_rt_addr,
    rd_addr: i_rd_addr,
    shamt:   i_shamt,
    funct:   i_funct
  };

  assign ex_mem_read = ctrl_q[MEM_READ_BIT];
  assign rt_match    = (payload_q.rt_addr == i_rs_addr) || (payload_q.rt_addr == i_rt_addr);
  assign stall       = ex_valid_q && ex_mem_read && i_id_valid && !i_flush &&
                       (payload_q.rt_addr != '0) && rt_match;
  assign bubble      = i_flush || stall;

  // Payload loads even on a bubble; only ctrl/valid are squashed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      payload_q  <= '0;
      ctrl_q     <= '0;
      ex_valid_q <= 1'b0;
    end else if (i_enable) begin
      payload_q  <= payload_d;
      ctrl_q     <= (bubble || !i_id_valid) ? '0 : i_ctrl;
      ex_valid_q <= !bubble && i_id_valid;
    end
  end

  assign o_ctrl     = ctrl_q;
  assign o_pc4      = payload_q.pc4;
  assign o_rs_data  = payload_q.rs_data;
  assign o_rt_data  = payload_q.rt_data;
  assign o_imm      = payload_q.imm;
  assign o_rs_addr  = payload_q.rs_addr;
  assign o_rt_addr  = payload_q.rt_addr;
  assign o_rd_addr  = payload_q.rd_addr;
  assign o_shamt    = payload_q.shamt;
  assign o_funct    = payload_q.funct;
  assign o_ex_valid = ex_valid_q;
  assign o_stall    = stall;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: reset, capture, load-use stall, flush, enable hold.
module tb_id_ex_stage_reg;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_enable;
  logic        i_flush;
  logic        i_id_valid;
  logic [15:0] i_ctrl;
  logic [31:0] i_pc4, i_rs_data, i_rt_data, i_imm;
  logic [4:0]  i_rs_addr, i_rt_addr, i_rd_addr;
  logic [4:0]  i_shamt;
  logic [5:0]  i_funct;
  logic [15:0] o_ctrl;
  logic [31:0] o_pc4, o_rs_data, o_rt_data, o_imm;
  logic [4:0]  o_rs_addr, o_rt_addr, o_rd_addr;
  logic [4:0]  o_shamt;
  logic [5:0]  o_funct;
  logic        o_ex_valid;
  logic        o_stall;

  int checks   = 0;
  int failures = 0;

  id_ex_stage_reg dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_enable   (i_enable),
    .i_flush    (i_flush),
    .i_id_valid (i_id_valid),
    .i_ctrl     (i_ctrl),
    .i_pc4      (i_pc4),
    .i_rs_data  (i_rs_data),
    .i_rt_data  (i_rt_data),
    .i_imm      (i_imm),
    .i_rs_addr  (i_rs_addr),
    .i_rt_addr  (i_rt_addr),
    .i_rd_addr  (i_rd_addr),
    .i_shamt    (i_shamt),
    .i_funct    (i_funct),
    .o_ctrl     (o_ctrl),
    .o_pc4      (o_pc4),
    .o_rs_data  (o_rs_data),
    .o_rt_data  (o_rt_data),
    .o_imm      (o_imm),
    .o_rs_addr  (o_rs_addr),
    .o_rt_addr  (o_rt_addr),
    .o_rd_addr  (o_rd_addr),
    .o_shamt    (o_shamt),
    .o_funct    (o_funct),
    .o_ex_valid (o_ex_valid),
    .o_stall    (o_stall)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"},     {16'h0, o_ctrl},    32'h0);
    check({tag, "_pc4"},      o_pc4,              32'h0);
    check({tag, "_rs_data"},  o_rs_data,          32'h0);
    check({tag, "_rt_data"},  o_rt_data,          32'h0);
    check({tag, "_imm"},      o_imm,              32'h0);
    check({tag, "_addrs"},    {17'h0, o_rs_addr, o_rt_addr, o_rd_addr}, 32'h0);
    check({tag, "_sh_fn"},    {21'h0, o_shamt, o_funct}, 32'h0);
    check({tag, "_ex_valid"}, {31'h0, o_ex_valid}, 32'h0);
    check({tag, "_stall"},    {31'h0, o_stall},    32'h0);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    // Power-up in reset
    i_rst_n = 1'b0; i_enable = 1'b1; i_flush = 1'b0; i_id_valid = 1'b0;
    i_ctrl = '0; i_pc4 = '0; i_rs_data = '0; i_rt_data = '0; i_imm = '0;
    i_rs_addr = '0; i_rt_addr = '0; i_rd_addr = '0; i_shamt = '0; i_funct = '0;
    #1;
    check_all_zero("reset0");
    #1 i_rst_n = 1'b1;

    // Normal capture: A5C3 has Mem_read set, so this instruction is an lw with rt=8
    i_id_valid = 1'b1; i_ctrl = 16'hA5C3; i_pc4 = 32'h0000_0014;
    i_rs_data = 32'h1234_5678; i_rt_data = 32'hCAFE_F00D; i_imm = 32'hFFFF_FFFC;
    i_rs_addr = 5'd1; i_rt_addr = 5'd8; i_rd_addr = 5'd17; i_shamt = 5'd3; i_funct = 6'h21;
    #1;
    check("cap_pre_stall", {31'h0, o_stall}, 32'h0);
    tick();
    check("cap_ctrl",     {16'h0, o_ctrl}, 32'h0000_A5C3);
    check("cap_pc4",      o_pc4,           32'h0000_0014);
    check("cap_rs_data",  o_rs_data,       32'h1234_5678);
    check("cap_rt_data",  o_rt_data,       32'hCAFE_F00D);
    check("cap_imm",      o_imm,           32'hFFFF_FFFC);
    check("cap_addrs",    {17'h0, o_rs_addr, o_rt_addr, o_rd_addr}, {17'h0, 5'd1, 5'd8, 5'd17});
    check("cap_sh_fn",    {21'h0, o_shamt, o_funct}, {21'h0, 5'd3, 6'h21});
    check("cap_ex_valid", {31'h0, o_ex_valid}, 32'h1);

    // Load-use: ID reads r8 while the lw writing r8 is in EX
    i_ctrl = 16'h8000; i_rs_addr = 5'd8; i_rt_addr = 5'd3; i_pc4 = 32'h0000_0018;
    #1;
    check("lu_stall", {31'h0, o_stall}, 32'h1);
    tick();
    check("lu_bubble_ctrl",  {16'h0, o_ctrl},     32'h0);
    check("lu_bubble_valid", {31'h0, o_ex_valid}, 32'h0);
    check("lu_stall_drop",   {31'h0, o_stall},    32'h0);
    tick();
    check("lu_capture_ctrl",  {16'h0, o_ctrl},     32'h0000_8000);
    check("lu_capture_valid", {31'h0, o_ex_valid}, 32'h1);
    check("lu_capture_pc4",   o_pc4,               32'h0000_0018);

    // Load into r0 never stalls
    i_ctrl = 16'h0080; i_rs_addr = 5'd5; i_rt_addr = 5'd0;
    tick();
    i_ctrl = 16'h8000; i_rs_addr = 5'd0; i_rt_addr = 5'd0;
    #1;
    check("zero_reg_stall", {31'h0, o_stall}, 32'h0);

    // Non-load in EX with matching rt never stalls
    i_ctrl = 16'hC000; i_rs_addr = 5'd1; i_rt_addr = 5'd9;
    tick();
    i_rs_addr = 5'd9; i_rt_addr = 5'd2;
    #1;
    check("no_load_stall", {31'h0, o_stall}, 32'h0);

    // Flush overrides a hazard
    i_ctrl = 16'h0080; i_rs_addr = 5'd1; i_rt_addr = 5'd10;
    tick();
    i_ctrl = 16'hC000; i_rs_addr = 5'd2; i_rt_addr = 5'd10;
    #1;
    check("flush_pre_stall", {31'h0, o_stall}, 32'h1);
    i_flush = 1'b1;
    #1;
    check("flush_stall", {31'h0, o_stall}, 32'h0);
    tick();
    check("flush_ctrl",  {16'h0, o_ctrl},     32'h0);
    check("flush_valid", {31'h0, o_ex_valid}, 32'h0);
    i_flush = 1'b0;

    // Enable hold for 3 cycles with changing inputs
    i_ctrl = 16'h1234; i_pc4 = 32'h0000_0100; i_rs_addr = 5'd1; i_rt_addr = 5'd2;
    tick();
    check("en_base_ctrl", {16'h0, o_ctrl}, 32'h0000_1234);
    i_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_ctrl = 16'h0F00 + 16'(i);
      i_pc4  = 32'h0000_0500 + 32'(i);
      tick();
      check("en_hold_ctrl",  {16'h0, o_ctrl},     32'h0000_1234);
      check("en_hold_pc4",   o_pc4,               32'h0000_0100);
      check("en_hold_valid", {31'h0, o_ex_valid}, 32'h1);
    end
    i_enable = 1'b1; i_ctrl = 16'h4321; i_pc4 = 32'h0000_0200;
    tick();
    check("en_resume_ctrl", {16'h0, o_ctrl}, 32'h0000_4321);
    check("en_resume_pc4",  o_pc4,           32'h0000_0200);

    // Enable low during a hazard keeps the stall asserted and state frozen
    i_ctrl = 16'h0080; i_rs_addr = 5'd1; i_rt_addr = 5'd11;
    tick();
    i_ctrl = 16'hC000; i_rs_addr = 5'd11; i_rt_addr = 5'd4;
    i_enable = 1'b0;
    tick();
    tick();
    check("en_hz_stall", {31'h0, o_stall},    32'h1);
    check("en_hz_ctrl",  {16'h0, o_ctrl},     32'h0000_0080);
    check("en_hz_valid", {31'h0, o_ex_valid}, 32'h1);
    i_enable = 1'b1;
    tick();
    check("en_hz_bubble_ctrl",  {16'h0, o_ctrl},     32'h0);
    check("en_hz_bubble_valid", {31'h0, o_ex_valid}, 32'h0);

    // Invalid ID instruction is captured as a bubble
    i_id_valid = 1'b0; i_ctrl = 16'hFFFF; i_pc4 = 32'h0000_0300; i_rs_addr = 5'd0;
    tick();
    check("inv_ctrl",  {16'h0, o_ctrl},     32'h0);
    check("inv_valid", {31'h0, o_ex_valid}, 32'h0);
    check("inv_pc4",   o_pc4,               32'h0000_0300);

    // Asynchronous reset in the middle of a stall
    i_id_valid = 1'b1; i_ctrl = 16'h0080; i_rs_addr = 5'd1; i_rt_addr = 5'd12;
    i_rs_data = 32'hDEAD_BEEF;
    tick();
    i_ctrl = 16'hC000; i_rs_addr = 5'd12; i_rt_addr = 5'd6;
    #1;
    check("mid_pre_stall", {31'h0, o_stall}, 32'h1);
    #2 i_rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Pipeline register between the decode stage (instruction decoder plus register file) and the execute stage.
- Captures the decoded control bundle and operand data for one instruction per cycle.
- Detects load-use hazards against the instruction currently held in EX and inserts bubbles.
- Supports branch/jump flush and a global enable used by the debug unit for single-step.

Parameters:
- NB_DATA, 32, width of PC and operand data paths.
- NB_REG, 5, register address width.
- NB_CTRL, 16, control bundle width.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_enable  in  1  global pipeline advance; 0 freezes every register.
- i_flush  in  1  branch/jump taken in ID; the instruction now in ID is squashed.
- i_id_valid  in  1  ID holds a real instruction.
- i_ctrl  in  NB_CTRL  control bundle, packed MSB→LSB as {Reg_write, ALU_source, Mem_write, ALU_op[2:0], Data_to_Reg[1:0], Mem_read, Reg_dst[1:0], Size_control[4:0]}.
- i_pc4  in  NB_DATA  PC+4 of the ID instruction.
- i_rs_data  in  NB_DATA  register file read port A.
- i_rt_data  in  NB_DATA  register file read port B.
- i_imm  in  NB_DATA  sign/zero-extended immediate.
- i_rs_addr  in  NB_REG  rs field.
- i_rt_addr  in  NB_REG  rt field.
- i_rd_addr  in  NB_REG  rd field.
- i_shamt  in  5  shamt field.
- i_funct  in  6  funct field.
- o_ctrl  out  NB_CTRL  registered control bundle.
- o_pc4, o_rs_data, o_rt_data, o_imm  out  NB_DATA  registered data.
- o_rs_addr, o_rt_addr, o_rd_addr  out  NB_REG  registered register addresses.
- o_shamt  out  5  registered shamt.
- o_funct  out  6  registered funct.
- o_ex_valid  out  1  EX holds a real instruction.
- o_stall  out  1  load-use hazard; PC and IF/ID must hold.

Behaviour:
- Reset (i_rst_n=0, asynchronous): all outputs and registers are 0; o_ex_valid=0. o_stall=0 follows, because it is derived from registered state.
- Hazard, combinational:
  - o_stall = o_ex_valid & ex_mem_read & i_id_valid & (o_rt_addr≠0) & ((o_rt_addr==i_rs_addr) | (o_rt_addr==i_rt_addr)).
  - ex_mem_read is o_ctrl bit 7 (Mem_read position).
  - o_stall is also qualified by ~i_flush: a flush overrides the stall.
- Update on rising i_clk, in priority order:
  1. i_enable=0: hold every register; o_stall still evaluates from the held state.
  2. i_flush=1 or o_stall=1: insert a bubble. o_ctrl=0 and o_ex_valid=0; data/address/shamt/funct registers load the inputs (don't-care, but deterministic).
  3. Otherwise: load all inputs. o_ex_valid=i_id_valid. o_ctrl=i_ctrl if i_id_valid, else 0.
- Latency: exactly 1 cycle, input to output.
- Stall duration: one bubble per load-use hazard. The next cycle the load has left EX, so o_stall drops and the held ID instruction is captured.
- Simultaneous flush and stall: the flush wins; one bubble is inserted and o_stall=0.
- Enable low during a hazard: o_stall stays asserted and nothing changes until enable returns.
- Reset asserted mid-stall: outputs clear immediately, not at the next edge.
- A bubble never writes the register file or memory, because all control bits are 0.

Test Plan:
- Reset: drive i_rst_n=0 asynchronously mid-cycle with nonzero outputs → all outputs 0 before the next edge; o_stall=0.
- Normal capture: i_ctrl=16'hA5C3, i_pc4=32'h0000_0014, i_rs_data=32'h1234_5678, i_id_valid=1 → values appear on outputs after 1 edge; o_ex_valid=1.
- Load-use stall: EX holds lw with o_rt_addr=8, Mem_read=1; ID has i_rs_addr=8 → o_stall=1. Next edge: o_ctrl=0, o_ex_valid=0. Following cycle: o_stall=0 and the ID instruction is captured.
- Zero-register and no-load checks:
  - o_rt_addr=0 with Mem_read=1 and i_rs_addr=0 → o_stall=0.
  - EX addi (Mem_read=0) matching rt → o_stall=0.
- Flush priority: i_flush=1 together with a hazard condition → o_stall=0; next edge o_ctrl=0, o_ex_valid=0.
- Enable hold: i_enable=0 for 3 cycles with changing inputs → outputs unchanged; i_enable=1 → capture resumes on the next edge.
